sm_imem_load_ctrl: RTL and testbench
====================================

SM_IMEM_LOAD_CTRL -- requirements
Module: sm_imem_load_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 11, instruction-memory word-address width.
REQ-002 Parameter: CLEAR_WORD, default 32'h0000_0000, value written by the clear sequence.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: load_en  in  1  level; 1 = loader mode, which maps to the latched ROM-write mode.
REQ-006 Port: clear_req  in  1  single-cycle request to clear the whole instruction memory.
REQ-007 Port: byte_valid  in  1  single-cycle strobe from the UART receiver.
REQ-008 Port: byte_data  in  8  received byte; qualified by byte_valid.
REQ-009 Port: cpu_addr  in  ADDR_W  CPU instruction fetch address.
REQ-010 Port: mem_addr  out  ADDR_W  shared instruction-memory address.
REQ-011 Port: mem_wdata  out  32  memory write data.
REQ-012 Port: mem_we  out  1  memory write enable.
REQ-013 Port: cpu_hold  out  1  1 = CPU does not own the memory port.
REQ-014 Port: busy  out  1  1 while in CLEAR state.
REQ-015 Port: wr_addr  out  ADDR_W  next load address, for LED display.
REQ-016 Port: last_word  out  32  last word written by the loader, for hex display.
REQ-017 Port: drop_err  out  1  sticky flag; a received byte was discarded.

Function
REQ-018 States: IDLE, LOAD, CLEAR; mem_addr/mem_we/mem_wdata ownership SHALL follow the state.
REQ-019 In IDLE, mem_addr SHALL equal cpu_addr combinationally.
REQ-020 In IDLE, mem_we SHALL be 0 and cpu_hold SHALL be 0.
REQ-021 Transitions: IDLE->LOAD when load_en=1; LOAD->IDLE when load_en=0; IDLE/LOAD->CLEAR when clear pending and no write in flight; CLEAR->LOAD/IDLE per load_en after the last clear write.
REQ-022 On entering LOAD from IDLE: wr_addr=0, byte count=0.
REQ-023 In LOAD, bytes SHALL assemble little-endian: first byte -> [7:0], fourth byte -> [31:24].
REQ-024 The 4th byte accepted in cycle n SHALL produce mem_we=1 for exactly cycle n+1, with mem_addr=wr_addr and mem_wdata=assembled word.
REQ-025 In cycle n+2, wr_addr SHALL be incremented and last_word SHALL be updated.
REQ-026 wr_addr SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-027 When LOAD is left with a partial word, the partial bytes SHALL be discarded and no write SHALL occur.
REQ-028 A clear_req pulse SHALL be latched as pending.
REQ-029 A pending clear SHALL be taken only when no mem_we is scheduled for the next cycle; an in-flight write completes first.
REQ-030 CLEAR writes CLEAR_WORD to addresses 0,1,...,2^ADDR_W-1, one per cycle, with mem_we=1 every cycle: exactly 2^ADDR_W cycles.
REQ-031 busy=1 and cpu_hold=1 throughout CLEAR.
REQ-032 On exit from CLEAR: wr_addr=0, byte count=0, pending clear=0.
REQ-033 clear_req asserted while in CLEAR SHALL be ignored and not re-latched.
REQ-034 byte_valid in IDLE or CLEAR SHALL discard the byte and set drop_err.
REQ-035 byte_valid coinciding with the clear being taken SHALL discard the byte and set drop_err.
REQ-036 drop_err SHALL clear only on reset.
REQ-037 cpu_hold=1 in LOAD and CLEAR.

Reset
REQ-038 rst=1 SHALL put the block in IDLE and zero byte count, wr_addr, last_word, drop_err, pending clear and mem_we.
REQ-039 Reset SHALL take effect on the next edge regardless of state, including mid-CLEAR.
REQ-040 After a reset mid-CLEAR, no further clear writes SHALL occur.

Verification (ADDR_W=4 in simulation)
REQ-041 load_en=1, bytes 78,56,34,12 -> one mem_we pulse at addr 0 with data 32'h12345678 one cycle after the 4th byte; wr_addr=1, last_word=32'h12345678.
REQ-042 wr_addr=15, 4 bytes sent -> write at addr 15, then wr_addr=0.
REQ-043 clear_req in IDLE -> busy=1 for 16 cycles, writes to addrs 0..15 with 0; then IDLE, cpu_hold=0.
REQ-044 4th byte at cycle n, clear_req at n+1 -> load write at n+1 completes first, CLEAR starts at n+2; byte_valid during CLEAR -> drop_err=1.
REQ-045 2 bytes sent, then load_en=0, then load_en=1, then 4 bytes AA,BB,CC,DD -> single write 32'hDDCCBBAA at addr 0.
REQ-046 rst at 5th CLEAR cycle -> next cycle mem_we=0, busy=0, state IDLE.

Source files
------------

// File: rtl/sm_imem_load_ctrl.sv
// Instruction-memory load controller: arbitrates the shared memory port between the CPU,
// a UART byte loader that packs bytes into little-endian words, and a full-memory clear.
module sm_imem_load_ctrl #(
    parameter int unsigned ADDR_W     = 11,
    parameter logic [31:0] CLEAR_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              clear_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       last_word,
    output logic              drop_err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        byte_cnt;
    logic [31:0]       word;
    logic              wr_pend;
    logic              clear_pend;
    logic [ADDR_W-1:0] clr_addr;

    logic load_beat;
    logic word_done;
    logic take_clear;
    logic clear_done;

    // A clear may not be taken in the cycle that schedules a load write.
    always_comb begin
        load_beat  = (state == LOAD) && byte_valid;
        word_done  = load_beat && (byte_cnt == 2'd3);
        take_clear = (state != CLEAR) && (clear_pend || clear_req) && !word_done;
        clear_done = (state == CLEAR) && (clr_addr == ADDR_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (take_clear) begin
                    state_next = CLEAR;
                end else if (load_en) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Stay until any scheduled or in-flight write has completed.
                if (take_clear) begin
                    state_next = CLEAR;
                end else if (!load_en && !word_done && !wr_pend) begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (clear_done) begin
                    state_next = load_en ? LOAD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            word       <= 32'd0;
            wr_pend    <= 1'b0;
            clear_pend <= 1'b0;
            clr_addr   <= '0;
            wr_addr    <= '0;
            last_word  <= 32'd0;
            drop_err   <= 1'b0;
        end else begin
            wr_pend <= word_done;
            if (byte_valid && ((state != LOAD) || take_clear)) begin
                drop_err <= 1'b1;
            end
            if (load_beat && !take_clear) begin
                word     <= {byte_data, word[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (wr_pend) begin
                wr_addr   <= wr_addr + ADDR_W'(1);
                last_word <= word;
            end
            if ((state == IDLE) && (state_next == LOAD)) begin
                wr_addr  <= '0;
                byte_cnt <= 2'd0;
            end
            if (state == CLEAR) begin
                clear_pend <= 1'b0;
            end else if (take_clear) begin
                clear_pend <= 1'b0;
            end else if (clear_req) begin
                clear_pend <= 1'b1;
            end
            if (take_clear) begin
                clr_addr <= '0;
                byte_cnt <= 2'd0;
            end else if (state == CLEAR) begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
            if (clear_done) begin
                wr_addr  <= '0;
                byte_cnt <= 2'd0;
            end
        end
    end

    // Memory port mux: clear owns it in CLEAR, otherwise a pending load write, else the CPU.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = word;
        if (state == CLEAR) begin
            mem_addr  = clr_addr;
            mem_we    = 1'b1;
            mem_wdata = CLEAR_WORD;
        end else if (wr_pend) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = word;
        end
    end

    always_comb begin
        busy     = (state == CLEAR);
        cpu_hold = (state != IDLE);
    end

endmodule

// File: tb/tb_sm_imem_load_ctrl.sv
// Scoreboard bench for sm_imem_load_ctrl (ADDR_W=4): expected memory writes are queued by
// the stimulus and checked by an independent monitor whenever mem_we is seen.
module tb_sm_imem_load_ctrl;

    localparam int unsigned AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic          clear_req;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic          cpu_hold;
    logic          busy;
    logic [AW-1:0] wr_addr;
    logic [31:0]   last_word;
    logic          drop_err;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];

    sm_imem_load_ctrl #(.ADDR_W(AW), .CLEAR_WORD(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .clear_req(clear_req),
        .byte_valid(byte_valid), .byte_data(byte_data), .cpu_addr(cpu_addr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .cpu_hold(cpu_hold), .busy(busy), .wr_addr(wr_addr),
        .last_word(last_word), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        send_byte(d[23:16]);
        send_byte(d[31:24]);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed write must match the head of the expectation queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    fails++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst        = 1'b1;
        load_en    = 1'b0;
        clear_req  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        cpu_addr   = 4'd5;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_last_word", last_word, 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd5);
        cpu_addr = 4'd9;
        #1;
        chk("idle_mem_addr_follow", 32'(mem_addr), 32'd9);

        // Basic word assembly and write timing.
        load_en = 1'b1;
        tick();
        chk("load_hold", 32'(cpu_hold), 32'd1);
        push_wr(4'd0, 32'h1234_5678);
        send_word(32'h1234_5678);
        chk("write_cycle_we", 32'(mem_we), 32'd1);
        tick();
        chk("after_write_we", 32'(mem_we), 32'd0);
        chk("after_write_wr_addr", 32'(wr_addr), 32'd1);
        chk("after_write_last_word", last_word, 32'h1234_5678);

        // Partial word dropped on leaving LOAD; re-entry restarts at address 0.
        send_byte(8'h11);
        send_byte(8'h22);
        load_en = 1'b0;
        tick();
        tick();
        chk("partial_idle_hold", 32'(cpu_hold), 32'd0);
        load_en = 1'b1;
        tick();
        chk("reenter_wr_addr", 32'(wr_addr), 32'd0);
        push_wr(4'd0, 32'hDDCC_BBAA);
        send_word(32'hDDCC_BBAA);
        tick();
        chk("partial_wr_addr", 32'(wr_addr), 32'd1);
        chk("partial_last_word", last_word, 32'hDDCC_BBAA);

        // Fill to the top address and wrap.
        for (int w = 1; w < 15; w++) begin
            push_wr(AW'(w), 32'h1000_0000 + 32'(w));
            send_word(32'h1000_0000 + 32'(w));
        end
        tick();
        chk("top_wr_addr", 32'(wr_addr), 32'd15);
        push_wr(4'd15, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        tick();
        chk("wrap_wr_addr", 32'(wr_addr), 32'd0);
        chk("wrap_last_word", last_word, 32'hCAFE_F00D);
        chk("no_drop_yet", 32'(drop_err), 32'd0);

        // Clear from IDLE; a clear_req inside CLEAR is ignored.
        load_en = 1'b0;
        tick();
        tick();
        chk("pre_clear_hold", 32'(cpu_hold), 32'd0);
        for (int a = 0; a < 16; a++) push_wr(AW'(a), 32'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            if (cpu_hold !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL clear_hold: got %b expected 1", cpu_hold);
            end
            cnt++;
            clear_req = (cnt == 3);
        end
        clear_req = 1'b0;
        chk("clear_cycles", 32'(cnt), 32'd16);
        tick();
        chk("post_clear_hold", 32'(cpu_hold), 32'd0);
        repeat (4) tick();
        chk("no_reclear", 32'(busy), 32'd0);

        // Write in flight finishes before CLEAR; byte during CLEAR is dropped.
        load_en = 1'b1;
        tick();
        push_wr(4'd0, 32'h0403_0201);
        for (int a = 0; a < 16; a++) push_wr(AW'(a), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        clear_req = 1'b1;
        chk("inflight_we", 32'(mem_we), 32'd1);
        chk("inflight_busy", 32'(busy), 32'd0);
        tick();
        clear_req = 1'b0;
        chk("clear_start_busy", 32'(busy), 32'd1);
        send_byte(8'h55);
        chk("drop_in_clear", 32'(drop_err), 32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
        end
        chk("clear2_done", 32'(busy), 32'd0);
        tick();
        chk("clear_to_load_hold", 32'(cpu_hold), 32'd1);
        chk("clear_exit_wr_addr", 32'(wr_addr), 32'd0);
        chk("drop_sticky", 32'(drop_err), 32'd1);

        // Reset during the 5th CLEAR cycle stops further clear writes.
        load_en = 1'b0;
        tick();
        tick();
        for (int a = 0; a < 5; a++) push_wr(AW'(a), 32'd0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (4) tick();
        chk("clear5_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_drop", 32'(drop_err), 32'd0);
        repeat (4) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
